// File: rtl/sparc_exu_ecc_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_ecc_pipe_if
// Description : Handshake, data and counter bundle for the EXU SEC-DED ECC
//               pipe. The master drives words in and consumes results; the
//               slave is the ECC engine.
// Revision    : 1.0  initial release
// ============================================================================
interface sparc_exu_ecc_pipe_if #(
    parameter int DATA_W = 64,
    parameter int CHK_W  = 8,
    parameter int CNT_W  = 16
);
    logic              in_vld;
    logic              in_rdy;
    logic              in_chk;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_ecc;
    logic [CHK_W-1:0]  in_msk;
    logic              out_vld;
    logic              out_rdy;
    logic [DATA_W-1:0] out_data;
    logic [CHK_W-1:0]  out_ecc;
    logic [CHK_W-1:0]  out_syn;
    logic              out_ce;
    logic              out_ue;
    logic              cnt_clr;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  ue_cnt;

    modport master (
        output in_vld, in_chk, in_data, in_ecc, in_msk, out_rdy, cnt_clr,
        input  in_rdy, out_vld, out_data, out_ecc, out_syn, out_ce, out_ue,
               ce_cnt, ue_cnt
    );

    modport slave (
        input  in_vld, in_chk, in_data, in_ecc, in_msk, out_rdy, cnt_clr,
        output in_rdy, out_vld, out_data, out_ecc, out_syn, out_ce, out_ue,
               ce_cnt, ue_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sparc_exu_ecc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_ecc_pipe
// Description : Stallable two-stage SEC-DED ECC engine. Generate mode emits
//               check bits (with optional error injection); check mode emits
//               syndrome, CE/UE flags, corrected data and its check bits, and
//               keeps saturating CE/UE counters.
// Revision    : 1.0  initial release
// ============================================================================
module sparc_exu_ecc_pipe #(
    parameter int DATA_W = 64,
    parameter int CHK_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    sparc_exu_ecc_pipe_if.slave bus
);

    localparam int c_hw   = CHK_W - 1;          // Hamming bits (no overall parity)
    localparam int c_ngrp = (DATA_W + 7) / 8;   // 8-bit partial-XOR groups

    // Codeword position of data bit k: k-th non-power-of-two from 3 upward.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned n;
        int unsigned r;
        n = 0;
        r = 0;
        for (int unsigned p = 3; p < 512; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) r = p;
                n++;
            end
        end
        return r;
    endfunction

    if ((DATA_W < 8) || (DATA_W > 64) || ((2 ** (CHK_W - 1)) < (DATA_W + CHK_W))) begin : g_bad_param
        $error("sparc_exu_ecc_pipe: illegal DATA_W/CHK_W combination");
    end

    logic [c_hw-1:0] w_pos [DATA_W];
    for (genvar k = 0; k < DATA_W; k++) begin : g_pos
        localparam int unsigned c_p = data_pos(k);
        assign w_pos[k] = c_hw'(c_p);
    end

    // ---------------- handshake control ----------------
    logic r_s1_vld;
    logic r_s2_vld;
    logic w_s2_free;
    logic w_in_rdy;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_free  = !r_s2_vld || bus.out_rdy;
    assign w_in_rdy   = !r_s1_vld || w_s2_free;
    assign w_s1_load  = bus.in_vld && w_in_rdy;
    assign w_s2_load  = r_s1_vld && w_s2_free;
    assign bus.in_rdy = w_in_rdy;

    // ---------------- stage 1 ----------------
    logic [c_hw-1:0]   w_part_h [c_ngrp];
    logic [c_ngrp-1:0] w_part_p;
    logic [c_hw-1:0]   r_s1_h   [c_ngrp];
    logic [c_ngrp-1:0] r_s1_p;
    logic              r_s1_chk;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_ecc;
    logic [CHK_W-1:0]  r_s1_msk;

    // Per-group partial Hamming sums and data parity of the incoming word.
    always_comb begin
        for (int g = 0; g < c_ngrp; g++) begin
            w_part_h[g] = '0;
            w_part_p[g] = 1'b0;
        end
        for (int k = 0; k < DATA_W; k++) begin
            w_part_h[k / 8] = w_part_h[k / 8] ^ (w_pos[k] & {c_hw{bus.in_data[k]}});
            w_part_p[k / 8] = w_part_p[k / 8] ^ bus.in_data[k];
        end
    end

    // Stage-1 register: captures partials and the raw word on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_chk  <= 1'b0;
            r_s1_data <= '0;
            r_s1_ecc  <= '0;
            r_s1_msk  <= '0;
            r_s1_p    <= '0;
            for (int g = 0; g < c_ngrp; g++) r_s1_h[g] <= '0;
        end else begin
            if (w_in_rdy) r_s1_vld <= bus.in_vld;
            if (w_s1_load) begin
                r_s1_chk  <= bus.in_chk;
                r_s1_data <= bus.in_data;
                r_s1_ecc  <= bus.in_ecc;
                r_s1_msk  <= bus.in_msk;
                r_s1_p    <= w_part_p;
                for (int g = 0; g < c_ngrp; g++) r_s1_h[g] <= w_part_h[g];
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [c_hw-1:0]   w_h;
    logic              w_dp;
    logic [CHK_W-1:0]  w_gen_ecc;
    logic [c_hw-1:0]   w_s;
    logic              w_pe;
    logic [DATA_W-1:0] w_flip;
    logic              w_hit;
    logic              w_s_pow2;
    logic              w_ce;
    logic              w_ue;
    logic [c_hw-1:0]   w_h_cor;
    logic              w_dp_cor;
    logic [CHK_W-1:0]  w_chk_ecc;

    // Reduce partials, decode the syndrome and build the corrected word.
    always_comb begin
        w_h = '0;
        for (int g = 0; g < c_ngrp; g++) w_h = w_h ^ r_s1_h[g];
        w_dp      = ^r_s1_p;
        w_gen_ecc = {(^w_h) ^ w_dp, w_h} ^ r_s1_msk;
        w_s       = w_h ^ r_s1_ecc[c_hw-1:0];
        w_pe      = w_dp ^ (^r_s1_ecc);
        for (int k = 0; k < DATA_W; k++) w_flip[k] = w_pe && (w_s == w_pos[k]);
        w_hit     = |w_flip;
        w_s_pow2  = (w_s != '0) && ((w_s & (w_s - c_hw'(1))) == '0);
        w_ce      = w_pe && ((w_s == '0) || w_s_pow2 || w_hit);
        w_ue      = ((w_s != '0) || w_pe) && !w_ce;
        // A corrected data bit at position s changes the Hamming sum by s
        // and the data parity by one.
        w_h_cor   = w_hit ? (w_h ^ w_s) : w_h;
        w_dp_cor  = w_dp ^ w_hit;
        w_chk_ecc = {(^w_h_cor) ^ w_dp_cor, w_h_cor};
    end

    logic              r_s2_ce;
    logic              r_s2_ue;
    logic [DATA_W-1:0] r_s2_data;
    logic [CHK_W-1:0]  r_s2_ecc;
    logic [CHK_W-1:0]  r_s2_syn;

    // Output register: advances when empty or the consumer takes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_ce   <= 1'b0;
            r_s2_ue   <= 1'b0;
            r_s2_data <= '0;
            r_s2_ecc  <= '0;
            r_s2_syn  <= '0;
        end else begin
            if (w_s2_free) r_s2_vld <= r_s1_vld;
            if (w_s2_load) begin
                if (r_s1_chk) begin
                    r_s2_data <= r_s1_data ^ w_flip;
                    r_s2_ecc  <= w_chk_ecc;
                    r_s2_syn  <= {w_pe, w_s};
                    r_s2_ce   <= w_ce;
                    r_s2_ue   <= w_ue;
                end else begin
                    r_s2_data <= r_s1_data;
                    r_s2_ecc  <= w_gen_ecc;
                    r_s2_syn  <= '0;
                    r_s2_ce   <= 1'b0;
                    r_s2_ue   <= 1'b0;
                end
            end
        end
    end

    assign bus.out_vld  = r_s2_vld;
    assign bus.out_data = r_s2_data;
    assign bus.out_ecc  = r_s2_ecc;
    assign bus.out_syn  = r_s2_syn;
    assign bus.out_ce   = r_s2_ce;
    assign bus.out_ue   = r_s2_ue;

    // ---------------- error counters ----------------
    logic             w_out_hs;
    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_ue_cnt;

    assign w_out_hs = r_s2_vld && bus.out_rdy;

    // Saturating CE/UE counters; clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else begin
            if (w_out_hs && r_s2_ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + CNT_W'(1);
            if (w_out_hs && r_s2_ue && (r_ue_cnt != '1)) r_ue_cnt <= r_ue_cnt + CNT_W'(1);
        end
    end

    assign bus.ce_cnt = r_ce_cnt;
    assign bus.ue_cnt = r_ue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_ecc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparc_exu_ecc_pipe
// Description : Directed self-checking bench for sparc_exu_ecc_pipe
//               (64-bit data / 8 check bits, plus a 2-bit-counter instance).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sparc_exu_ecc_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparc_exu_ecc_pipe_if #(.DATA_W(64), .CHK_W(8), .CNT_W(16)) bus  ();
    sparc_exu_ecc_pipe_if #(.DATA_W(64), .CHK_W(8), .CNT_W(2))  bus2 ();

    sparc_exu_ecc_pipe #(.DATA_W(64), .CHK_W(8), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sparc_exu_ecc_pipe #(.DATA_W(64), .CHK_W(8), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ce  = 0;
    int exp_ue  = 0;
    bit saw_rdy_low = 1'b0;
    logic [63:0] got [$];
    logic [63:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word on bus and wait (bounded) until it is accepted.
    task automatic push(input logic chk, input logic [63:0] d, input logic [7:0] e, input logic [7:0] m);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_chk  = chk;
        bus.in_data = d;
        bus.in_ecc  = e;
        bus.in_msk  = m;
        for (int i = 0; i < 20 && !ok; i++) begin
            #2;
            if (bus.in_rdy) begin
                ok = 1'b1;
                @(posedge clk);
            end else begin
                saw_rdy_low = 1'b1;
                @(negedge clk);
            end
        end
        if (!ok) check("push_accept", {63'd0, ok}, 64'd1);
    endtask

    // One isolated word with out_rdy=1: checks latency, result and counters.
    task automatic single(input string tag, input logic chk, input logic [63:0] d,
                          input logic [7:0] e, input logic [7:0] m,
                          input logic [63:0] x_data, input logic [7:0] x_ecc,
                          input logic [7:0] x_syn, input logic x_ce, input logic x_ue);
        push(chk, d, e, m);
        @(negedge clk);
        bus.in_vld = 1'b0;
        check({tag, "_lat"}, bus.out_vld, 1'b0);
        @(negedge clk);
        check({tag, "_vld"},  bus.out_vld,  1'b1);
        check({tag, "_data"}, bus.out_data, x_data);
        check({tag, "_ecc"},  bus.out_ecc,  x_ecc);
        check({tag, "_syn"},  bus.out_syn,  x_syn);
        check({tag, "_ce"},   bus.out_ce,   x_ce);
        check({tag, "_ue"},   bus.out_ue,   x_ue);
        if (x_ce) exp_ce++;
        if (x_ue) exp_ue++;
        @(negedge clk);
        check({tag, "_cecnt"}, bus.ce_cnt, exp_ce);
        check({tag, "_uecnt"}, bus.ue_cnt, exp_ue);
        check({tag, "_drain"}, bus.out_vld, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_vld = 0; bus.in_chk = 0; bus.in_data = '0; bus.in_ecc = '0; bus.in_msk = '0;
        bus.out_rdy = 1; bus.cnt_clr = 0;
        bus2.in_vld = 0; bus2.in_chk = 1; bus2.in_data = '0; bus2.in_ecc = 8'h83; bus2.in_msk = '0;
        bus2.out_rdy = 1; bus2.cnt_clr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_vld",   bus.out_vld,  1'b0);
        check("rst_rdy",   bus.in_rdy,   1'b1);
        check("rst_data",  bus.out_data, 64'd0);
        check("rst_ecc",   bus.out_ecc,  8'h00);
        check("rst_syn",   bus.out_syn,  8'h00);
        check("rst_ceue",  {bus.out_ce, bus.out_ue}, 2'b00);
        check("rst_cecnt", bus.ce_cnt,   16'd0);
        check("rst_uecnt", bus.ue_cnt,   16'd0);

        // Generate mode
        single("gen0",   0, 64'h0, 8'h00, 8'h00, 64'h0, 8'h00, 8'h00, 0, 0);
        single("gen1",   0, 64'h1, 8'h00, 8'h00, 64'h1, 8'h83, 8'h00, 0, 0);
        single("genmsk", 0, 64'h0, 8'h00, 8'h01, 64'h0, 8'h01, 8'h00, 0, 0);
        single("gen2",   0, 64'h2, 8'h00, 8'h00, 64'h2, 8'h85, 8'h00, 0, 0);
        single("gen63",  0, 64'h8000_0000_0000_0000, 8'h00, 8'h00,
               64'h8000_0000_0000_0000, 8'hC7, 8'h00, 0, 0);
        single("genecc", 0, 64'h1, 8'hFF, 8'h00, 64'h1, 8'h83, 8'h00, 0, 0);

        // Check mode
        single("chk_d0",   1, 64'h0, 8'h83, 8'h00, 64'h1, 8'h83, 8'h83, 1, 0);
        single("chk_ue",   1, 64'h2, 8'h83, 8'h00, 64'h2, 8'h85, 8'h06, 0, 1);
        single("chk_ok",   1, 64'h1, 8'h83, 8'h00, 64'h1, 8'h83, 8'h00, 0, 0);
        single("chk_par",  1, 64'h0, 8'h80, 8'h00, 64'h0, 8'h00, 8'h80, 1, 0);
        single("chk_cb",   1, 64'h0, 8'h04, 8'h00, 64'h0, 8'h00, 8'h84, 1, 0);
        single("chk_oor",  1, 64'h0, 8'h7F, 8'h00, 64'h0, 8'h00, 8'hFF, 0, 1);
        single("chk_d63",  1, 64'h0, 8'hC7, 8'h00, 64'h8000_0000_0000_0000, 8'hC7, 8'hC7, 1, 0);

        // Back-to-back words with consumer stalled on cycles 3..6
        got.delete();
        saw_rdy_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(0, 64'hA000 + 64'(i), 8'h00, 8'h00);
                @(negedge clk);
                bus.in_vld = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    bus.out_rdy = !(c >= 3 && c <= 6);
                    #1;
                    if (c == 3) begin
                        held = bus.out_data;
                        check("stall_vld", bus.out_vld, 1'b1);
                    end
                    if (c >= 4 && c <= 6) check("stall_hold", bus.out_data, held);
                    if (bus.out_vld && bus.out_rdy) got.push_back(bus.out_data);
                end
            end
        join
        bus.out_rdy = 1'b1;
        check("bp_rdy_low", {63'd0, saw_rdy_low}, 64'd1);
        check("bp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) check("bp_order", got[i], 64'hA000 + 64'(i));
        end

        // 2-bit saturating counter with a clear coinciding with a CE handshake
        for (int c = 0; c < 8; c++) begin
            logic [1:0] x_cnt [8];
            x_cnt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
            @(negedge clk);
            check("sat_cecnt", bus2.ce_cnt, x_cnt[c]);
            bus2.in_vld  = (c < 5);
            bus2.cnt_clr = (c == 6);
        end
        check("sat_uecnt", bus2.ue_cnt, 2'd0);
        check("sat_drain", bus2.out_vld, 1'b0);

        // Reset with two words in flight
        bus.out_rdy = 1'b0;
        push(1, 64'h0, 8'h83, 8'h00);
        push(1, 64'h2, 8'h83, 8'h00);
        @(negedge clk);
        bus.in_vld = 1'b0;
        check("mid_full_vld", bus.out_vld, 1'b1);
        check("mid_full_rdy", bus.in_rdy,  1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_async_vld", bus.out_vld, 1'b0);
        @(negedge clk);
        check("mid_rst_vld",   bus.out_vld,  1'b0);
        check("mid_rst_cecnt", bus.ce_cnt,   16'd0);
        check("mid_rst_uecnt", bus.ue_cnt,   16'd0);
        check("mid_rst_data",  bus.out_data, 64'd0);
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        exp_ce = 0;
        exp_ue = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_idle", bus.out_vld, 1'b0);
        end
        single("post_rst", 0, 64'h1, 8'h00, 8'h00, 64'h1, 8'h83, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
